ctrl_pipe_regs: RTL and testbench

//  Pipeline register chain for control and register-tag fields, ID/EX -> EX/MEM -> MEM/WB.

---
 rtl/ctrl_pipe_regs.sv | 140 ++++++++++++++
 tb/tb_ctrl_pipe_regs.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_regs.sv
// ID/EX -> EX/MEM -> MEM/WB control and register-tag pipeline with branch/jump flush generation.
// Optional CTRL_PERF_CNT_EN adds saturating stall/flush performance counters.
module ctrl_pipe_regs #(
  parameter int REG_AW = 5,
  parameter int ALUC_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_regdst,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic [ALUC_W-1:0] id_aluctrl,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              bubble_idex,
  input  logic              ex_zero,
  output logic              idex_regdst,
  output logic              idex_alusrc,
  output logic              idex_branch,
  output logic              idex_memread,
  output logic              idex_memwrite,
  output logic              idex_memtoreg,
  output logic              idex_regwrite,
  output logic [ALUC_W-1:0] idex_aluctrl,
  output logic [REG_AW-1:0] idex_rs,
  output logic [REG_AW-1:0] idex_rt,
  output logic [REG_AW-1:0] idex_rd,
  output logic              exmem_memread,
  output logic              exmem_memwrite,
  output logic              exmem_memtoreg,
  output logic              exmem_regwrite,
  output logic              exmem_branch,
  output logic              exmem_zero,
  output logic [REG_AW-1:0] exmem_rd,
  output logic              memwb_memtoreg,
  output logic              memwb_regwrite,
  output logic [REG_AW-1:0] memwb_rd,
  output logic              pcsrc,
  output logic              flush_ifid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int IW = 7 + ALUC_W;

  logic [IW-1:0]     idex_c_d, idex_c_q;
  logic [REG_AW-1:0] idex_rs_q, idex_rt_q, idex_rd_q;
  logic [5:0]        exmem_c_d, exmem_c_q;
  logic [REG_AW-1:0] exmem_rd_d, exmem_rd_q;
  logic [1:0]        memwb_c_q;
  logic [REG_AW-1:0] memwb_rd_q;

  assign {idex_regdst, idex_alusrc, idex_branch, idex_memread, idex_memwrite,
          idex_memtoreg, idex_regwrite, idex_aluctrl} = idex_c_q;
  assign idex_rs = idex_rs_q;
  assign idex_rt = idex_rt_q;
  assign idex_rd = idex_rd_q;
  assign {exmem_memread, exmem_memwrite, exmem_memtoreg, exmem_regwrite,
          exmem_branch, exmem_zero} = exmem_c_q;
  assign exmem_rd = exmem_rd_q;
  assign {memwb_memtoreg, memwb_regwrite} = memwb_c_q;
  assign memwb_rd = memwb_rd_q;

  assign pcsrc      = exmem_branch & exmem_zero;
  assign flush_ifid = pcsrc | (id_jump & ~bubble_idex);

  // Jumps also zero the ID/EX controls so the decoder's don't-cares never propagate.
  always_comb begin
    idex_c_d   = '0;
    exmem_c_d  = '0;
    exmem_rd_d = idex_regdst ? idex_rd_q : idex_rt_q;
    if (!(pcsrc | bubble_idex | id_jump)) begin
      idex_c_d = {id_regdst, id_alusrc, id_branch, id_memread, id_memwrite,
                  id_memtoreg, id_regwrite, id_aluctrl};
    end
    if (!pcsrc) begin
      exmem_c_d = {idex_memread, idex_memwrite, idex_memtoreg, idex_regwrite,
                   idex_branch, ex_zero};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idex_c_q   <= '0;
      idex_rs_q  <= '0;
      idex_rt_q  <= '0;
      idex_rd_q  <= '0;
      exmem_c_q  <= '0;
      exmem_rd_q <= '0;
      memwb_c_q  <= '0;
      memwb_rd_q <= '0;
    end else begin
      idex_c_q   <= idex_c_d;
      idex_rs_q  <= id_rs;
      idex_rt_q  <= id_rt;
      idex_rd_q  <= id_rd;
      exmem_c_q  <= exmem_c_d;
      exmem_rd_q <= exmem_rd_d;
      memwb_c_q  <= {exmem_memtoreg, exmem_regwrite};
      memwb_rd_q <= exmem_rd_q;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // A bubble overridden by a taken branch counts as a flush, not a stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bubble_idex && !pcsrc && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (pcsrc && !(&flush_cnt_q))                 flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Self-checking bench for ctrl_pipe_regs: random and directed instruction streams vs an
// instruction-record model of the three pipeline slots.
module tb_ctrl_pipe_regs;

  localparam int CNT_W = 2;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic id_regdst, id_branch, id_jump, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regwrite;
  logic [1:0] id_aluctrl;
  logic [4:0] id_rs, id_rt, id_rd;
  logic bubble_idex, ex_zero;
  logic idex_regdst, idex_alusrc, idex_branch, idex_memread, idex_memwrite, idex_memtoreg, idex_regwrite;
  logic [1:0] idex_aluctrl;
  logic [4:0] idex_rs, idex_rt, idex_rd;
  logic exmem_memread, exmem_memwrite, exmem_memtoreg, exmem_regwrite, exmem_branch, exmem_zero;
  logic [4:0] exmem_rd;
  logic memwb_memtoreg, memwb_regwrite;
  logic [4:0] memwb_rd;
  logic pcsrc, flush_ifid;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  ctrl_pipe_regs #(.REG_AW(5), .ALUC_W(2), .CNT_W(CNT_W)) dut (
    .clock(clk), .reset(rst_n),
    .id_regdst(id_regdst), .id_branch(id_branch), .id_jump(id_jump), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc),
    .id_regwrite(id_regwrite), .id_aluctrl(id_aluctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .bubble_idex(bubble_idex), .ex_zero(ex_zero),
    .idex_regdst(idex_regdst), .idex_alusrc(idex_alusrc), .idex_branch(idex_branch),
    .idex_memread(idex_memread), .idex_memwrite(idex_memwrite), .idex_memtoreg(idex_memtoreg),
    .idex_regwrite(idex_regwrite), .idex_aluctrl(idex_aluctrl),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite), .exmem_memtoreg(exmem_memtoreg),
    .exmem_regwrite(exmem_regwrite), .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
    .exmem_rd(exmem_rd),
    .memwb_memtoreg(memwb_memtoreg), .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
    .pcsrc(pcsrc), .flush_ifid(flush_ifid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // One in-flight instruction: decoded fields plus whether its controls are still alive.
  typedef struct packed {
    bit       live;
    bit       regdst, alusrc, branch, memread, memwrite, memtoreg, regwrite;
    bit [1:0] aluc;
    bit [4:0] rs, rt, rd, dest;
    bit       zero;
  } ins_t;

  ins_t s_idex, s_exmem, s_memwb;
  int   m_stall, m_flush;
  int   n_cmp = 0;
  int   n_err = 0;

  // Instruction-class encodings: {regdst, branch, jump, memread, memwrite, memtoreg, alusrc, regwrite}
  localparam logic [7:0] NOP   = 8'b0000_0000;
  localparam logic [7:0] RTYPE = 8'b1000_0001;
  localparam logic [7:0] LW    = 8'b0001_0111;
  localparam logic [7:0] BEQ   = 8'b0100_0000;
  localparam logic [7:0] ADDI  = 8'b0000_0011;
  localparam logic [7:0] RWST  = 8'b1000_1001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v;
  endfunction

  function automatic bit m_pcsrc();
    return s_exmem.live && s_exmem.branch && s_exmem.zero;
  endfunction

  task automatic model_reset();
    s_idex = '0; s_exmem = '0; s_memwb = '0;
    m_stall = 0; m_flush = 0;
  endtask

  task automatic model_step();
    ins_t n;
    bit   tk;
    tk = m_pcsrc();
    if (PERF && tk) m_flush = sat(m_flush + 1);
    if (PERF && !tk && bubble_idex === 1'b1) m_stall = sat(m_stall + 1);
    s_memwb = s_exmem;
    n = s_idex;
    n.dest = (s_idex.live && s_idex.regdst) ? s_idex.rd : s_idex.rt;
    n.zero = tk ? 1'b0 : ex_zero;
    if (tk) n.live = 1'b0;
    s_exmem = n;
    n = '0;
    n.live = !(tk || bubble_idex === 1'b1 || id_jump === 1'b1);
    {n.regdst, n.alusrc, n.branch, n.memread, n.memwrite, n.memtoreg, n.regwrite} =
      {id_regdst, id_alusrc, id_branch, id_memread, id_memwrite, id_memtoreg, id_regwrite};
    n.aluc = id_aluctrl;
    n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
    s_idex = n;
  endtask

  task automatic check_regs();
    bit l0, l1, l2;
    l0 = s_idex.live; l1 = s_exmem.live; l2 = s_memwb.live;
    chk("idex_regdst",   idex_regdst,   l0 & s_idex.regdst);
    chk("idex_alusrc",   idex_alusrc,   l0 & s_idex.alusrc);
    chk("idex_branch",   idex_branch,   l0 & s_idex.branch);
    chk("idex_memread",  idex_memread,  l0 & s_idex.memread);
    chk("idex_memwrite", idex_memwrite, l0 & s_idex.memwrite);
    chk("idex_memtoreg", idex_memtoreg, l0 & s_idex.memtoreg);
    chk("idex_regwrite", idex_regwrite, l0 & s_idex.regwrite);
    chk("idex_aluctrl",  idex_aluctrl,  l0 ? s_idex.aluc : 2'b00);
    chk("idex_rs", idex_rs, s_idex.rs);
    chk("idex_rt", idex_rt, s_idex.rt);
    chk("idex_rd", idex_rd, s_idex.rd);
    chk("exmem_memread",  exmem_memread,  l1 & s_exmem.memread);
    chk("exmem_memwrite", exmem_memwrite, l1 & s_exmem.memwrite);
    chk("exmem_memtoreg", exmem_memtoreg, l1 & s_exmem.memtoreg);
    chk("exmem_regwrite", exmem_regwrite, l1 & s_exmem.regwrite);
    chk("exmem_branch",   exmem_branch,   l1 & s_exmem.branch);
    chk("exmem_zero",     exmem_zero,     s_exmem.zero);
    if (l1) chk("exmem_rd", exmem_rd, s_exmem.dest);
    chk("memwb_memtoreg", memwb_memtoreg, l2 & s_memwb.memtoreg);
    chk("memwb_regwrite", memwb_regwrite, l2 & s_memwb.regwrite);
    if (l2) chk("memwb_rd", memwb_rd, s_memwb.dest);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
  endtask

  task automatic drive(input logic [7:0] c, input logic [1:0] a, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic bub, input logic z);
    {id_regdst, id_branch, id_jump, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regwrite} = c;
    id_aluctrl = a; id_rs = rs; id_rt = rt; id_rd = rd;
    bubble_idex = bub; ex_zero = z;
  endtask

  task automatic drive_nop();
    drive(NOP, 2'b00, 5'($urandom), 5'($urandom), 5'($urandom), 1'b0, 1'($urandom));
  endtask

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic cycle();
    #1;
    chk("pcsrc", pcsrc, m_pcsrc());
    chk("flush_ifid", flush_ifid, m_pcsrc() | (id_jump & ~bubble_idex));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_regs();
  endtask

  task automatic random_cycles(input int n);
    logic [7:0] c;
    for (int i = 0; i < n; i++) begin
      c = 8'($urandom);
      c[6] = ($urandom_range(0, 2) == 0);
      c[5] = ($urandom_range(0, 7) == 0);
      drive(c, 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            ($urandom_range(0, 3) == 0), 1'($urandom));
      cycle();
    end
  endtask

  initial begin
    int f0, s0;
    rst_n = 1'b0;
    drive(NOP, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    check_regs();
    rst_n = 1'b1;

    random_cycles(150);

    // Asynchronous reset mid-stream with live inputs, then release with an R-type (rd=3) in ID.
    drive(RWST, 2'b10, 5'd1, 5'd2, 5'd4, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_idex_regwrite", idex_regwrite, 1'b0);
    chk("rst_idex_rd", idex_rd, 5'd0);
    chk("rst_exmem_regwrite", exmem_regwrite, 1'b0);
    chk("rst_exmem_rd", exmem_rd, 5'd0);
    chk("rst_memwb_regwrite", memwb_regwrite, 1'b0);
    chk("rst_memwb_rd", memwb_rd, 5'd0);
    chk("rst_pcsrc", pcsrc, 1'b0);
    chk("rst_flush_ifid", flush_ifid, 1'b0);
    chk("rst_stall_cnt", stall_cnt, 2'd0);
    chk("rst_flush_cnt", flush_cnt, 2'd0);
    @(negedge clk);
    check_regs();
    rst_n = 1'b1;
    drive(RTYPE, 2'b10, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    cycle();
    drive_nop(); cycle();
    drive_nop(); cycle();
    chk("rel_memwb_regwrite", memwb_regwrite, 1'b1);
    chk("rel_memwb_rd", memwb_rd, 5'd3);

    // Load-use: LW rt=5, then a bubble.
    drive(LW, 2'b00, 5'd2, 5'd5, 5'd9, 1'b0, 1'b0);
    cycle();
    drive(RTYPE, 2'b10, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
    cycle();
    chk("lu_idex_regwrite", idex_regwrite, 1'b0);
    chk("lu_idex_memread", idex_memread, 1'b0);
    chk("lu_exmem_memread", exmem_memread, 1'b1);
    chk("lu_exmem_rd", exmem_rd, 5'd5);
    drive_nop(); cycle();
    drive_nop(); cycle();

    // Taken BEQ; the pcsrc cycle also carries a bubble request.
    drive(BEQ, 2'b01, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    cycle();
    drive(RWST, 2'b10, 5'd3, 5'd4, 5'd10, 1'b0, 1'b1);
    cycle();
    chk("tk_pcsrc_hi", pcsrc, 1'b1);
    s0 = stall_cnt; f0 = flush_cnt;
    drive(RWST, 2'b10, 5'd3, 5'd4, 5'd11, 1'b1, 1'b0);
    cycle();
    chk("tk_pcsrc_lo", pcsrc, 1'b0);
    chk("tk_x_exmem_regwrite", exmem_regwrite, 1'b0);
    chk("tk_x_exmem_memwrite", exmem_memwrite, 1'b0);
    chk("tk_stall_hold", stall_cnt, s0);
    chk("tk_flush_inc", flush_cnt, PERF ? sat(f0 + 1) : 0);
    drive_nop(); cycle();
    chk("tk_y_exmem_regwrite", exmem_regwrite, 1'b0);
    chk("tk_y_exmem_memwrite", exmem_memwrite, 1'b0);
    chk("tk_x_memwb_regwrite", memwb_regwrite, 1'b0);
    drive_nop(); cycle();
    chk("tk_y_memwb_regwrite", memwb_regwrite, 1'b0);

    // Not-taken BEQ followed by ADDI rt=7.
    drive(BEQ, 2'b01, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    cycle();
    drive(ADDI, 2'b00, 5'd1, 5'd7, 5'd12, 1'b0, 1'b0);
    cycle();
    chk("nt_pcsrc", pcsrc, 1'b0);
    drive_nop(); cycle();
    drive_nop(); cycle();
    chk("nt_memwb_regwrite", memwb_regwrite, 1'b1);
    chk("nt_memwb_rd", memwb_rd, 5'd7);

    // Jump with unknown decoder outputs.
    drive_nop(); cycle();
    {id_regdst, id_branch, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regwrite} = 'x;
    id_aluctrl = 'x;
    id_jump = 1'b1; bubble_idex = 1'b0;
    #1;
    chk("j_flush_ifid", flush_ifid, 1'b1);
    cycle();
    chk("j_idex_regdst", idex_regdst, 1'b0);
    chk("j_idex_regwrite", idex_regwrite, 1'b0);
    chk("j_idex_memwrite", idex_memwrite, 1'b0);
    chk("j_idex_branch", idex_branch, 1'b0);
    chk("j_idex_aluctrl", idex_aluctrl, 2'b00);

    // Five bubble cycles saturate the 2-bit stall counter.
    for (int i = 0; i < 5; i++) begin
      drive(NOP, 2'b00, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b0);
      cycle();
    end
    chk("sat_stall_cnt", stall_cnt, PERF ? 2'd3 : 2'd0);

    random_cycles(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
